// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, wrap/saturate limits and a limit-event flag.
// Define UPDOWN_COUNTER_STICKY_FLAG_EN for a sticky flag cleared by clear_flag; otherwise flag is a one-cycle pulse.
module updown_counter_mod #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] counter_out,
  output logic             at_max,
  output logic             at_min,
  output logic             flag
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_clamped;
  logic             limit_event;

  // Loads are clamped so the count can never leave 0..MAX_VAL, even for a non-power-of-two modulus.
  always_comb begin
    count_d      = count_q;
    limit_event  = 1'b0;
    load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      if (direction) begin
        if (count_q == MAX_VAL) begin
          limit_event = 1'b1;
          count_d     = sat_mode ? MAX_VAL : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          limit_event = 1'b1;
          count_d     = sat_mode ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      flag    <= 1'b0;
    end else begin
      count_q <= count_d;
`ifdef UPDOWN_COUNTER_STICKY_FLAG_EN
      if (limit_event) begin
        flag <= 1'b1;
      end else if (clear_flag) begin
        flag <= 1'b0;
      end
`else
      flag <= limit_event;
`endif
    end
  end

`ifndef UPDOWN_COUNTER_STICKY_FLAG_EN
  // In the pulse build clear_flag has no effect; the port stays for a uniform interface.
  logic unused_clear_flag;
  assign unused_clear_flag = clear_flag;
`endif

  assign counter_out = count_q;
  assign at_max      = (count_q == MAX_VAL);
  assign at_min      = (count_q == '0);

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter: successor to the fixed 8-bit enable/direction counter, generalised to any width and any modulus. Adds:
- synchronous parallel load
- selectable wrap or saturate at the limits
- limit indicators
- an overflow/underflow event flag

It is the counting primitive for timers, decade counters and position trackers in the design.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- MAX_VAL, 2**WIDTH-1, highest count value; legal range 1..2**WIDTH-1; count range is 0..MAX_VAL

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserts immediately on rst=0; releases synchronously in effect at next clk edge after rst=1)
- enable  input  1  count enable; 0 = hold
- direction  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_value  input  WIDTH  value loaded when load=1
- sat_mode  input  1  1 = saturate at limits, 0 = wrap
- clear_flag  input  1  synchronous clear of flag
- counter_out  output  WIDTH  registered count
- at_max  output  1  counter_out == MAX_VAL (combinational from register)
- at_min  output  1  counter_out == 0 (combinational from register)
- flag  output  1  limit event indicator, registered

## Operation
- Per-edge priority: rst=0 > load > enable > hold.
- load=1: counter_out <= min(load_value, MAX_VAL); enable/direction ignored; flag not set by a load.
- enable=1, load=0, direction=1:
  - counter_out < MAX_VAL: increment by 1.
  - counter_out == MAX_VAL, sat_mode=0: wrap to 0, limit event.
  - counter_out == MAX_VAL, sat_mode=1: hold at MAX_VAL, limit event (attempted overflow).
- enable=1, load=0, direction=0: mirror image at 0.
  - Wrap goes to MAX_VAL.
  - Saturate holds at 0.
  - Both are limit events.
- enable=0, load=0: counter_out, flag behaviour per Configuration; count holds.
- Arithmetic is WIDTH bits; never produces a value > MAX_VAL, even when MAX_VAL < 2**WIDTH-1.
- direction and sat_mode may change every cycle; only the value sampled at the edge matters.

## Timing
- Reset values while rst=0: counter_out=0, flag=0, at_min=1, at_max=0.
- Count, load and flag update take effect at the clk edge where they are sampled; visible 1 cycle after inputs are set.
- at_max/at_min follow counter_out with zero additional latency.
- Limit event registers flag on the same edge that wraps/saturates the count.
- Simultaneous limit event and clear_flag=1: event wins, flag=1.
- Reset asserted mid-count: counter_out and flag clear immediately, without waiting for clk. First count after release occurs on the first edge with rst=1.

## Configuration
- Macro UPDOWN_COUNTER_STICKY_FLAG_EN.
- Defined:
  - flag is sticky: set by any limit event.
  - Stays 1 until a clk edge with clear_flag=1 and no concurrent event, or until reset.
- Undefined:
  - flag is a single-cycle pulse: 1 for exactly the cycle after a limit event, 0 otherwise.
  - clear_flag is ignored.
- Port list is identical in both builds.

## Test plan
Use WIDTH=8, MAX_VAL=9 unless stated.
- Reset: counter running at 5, drive rst=0 between edges -> counter_out=0 and flag=0 immediately, at_min=1; release, enable=1, direction=1 -> 1 after first edge.
- Wrap up/down: sat_mode=0, count up from 0 for 10 edges -> sequence 1..9 then 0; flag event on the 9->0 edge. Direction=0 from 0 -> 9, at_max=1.
- Saturate: sat_mode=1, load 8, count up 3 edges -> 9,9,9; at_max=1; flag event on each hold edge. Down from 0 -> stays 0.
- Load priority and clamp: load=1, enable=1, load_value=200 -> counter_out=9 next edge, no flag. load_value=4 with direction=0 -> 4, not 3.
- Flag behaviour:
  - Sticky build: event then 3 idle cycles -> flag stays 1. clear_flag=1 -> 0 next edge. clear_flag concurrent with wrap -> flag stays 1.
  - Pulse build: flag high exactly one cycle per event.
- Full-width: WIDTH=4, MAX_VAL=15 -> 15 wraps to 0 on up, 0 to 15 on down; enable=0 holds value for 5 edges.
